// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal frame controller.
// Optional statistics are enabled with the BITREV_CTRL_STATS_EN macro (see top level).
package bitrev_pkg;

    localparam int BR_K_DEF  = 10;  // default log2 frame length
    localparam int BR_FW_DEF = 16;  // default frame-counter width
    localparam int BR_MAX_K  = 16;  // widest frame address the reversal helper supports

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reverse the low k bits of value. Mirror the whole word, then shift
    // the mirrored field down so it lands in bits [k-1:0].
    function automatic logic [BR_MAX_K-1:0] bit_reverse(input logic [BR_MAX_K-1:0] value,
                                                        input int k);
        logic [BR_MAX_K-1:0] mirrored;
        mirrored = '0;
        for (int i = 0; i < BR_MAX_K; i++) begin
            mirrored[i] = value[BR_MAX_K-1-i];
        end
        return mirrored >> (BR_MAX_K - k);
    endfunction

endpackage

// File: rtl/bitrev_rd_seq.sv
// Read sequencer: walks each full bank in bit-reversed order and owns the
// output valid/last register that mirrors the buffer's registered read data.
module bitrev_rd_seq
    import bitrev_pkg::*;
#(
    parameter int K = BR_K_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [1:0]   full,
    input  logic         out_ready,
    output logic         rd_en,
    output logic         rd_bank,
    output logic [K-1:0] rd_addr,
    output logic         frame_read,
    output logic         out_valid,
    output logic         out_last
);

    logic [K-1:0] rd_cnt_reg;
    logic         rd_bank_reg;
    logic         out_valid_reg;
    logic         last_pend_reg;

    // A read may issue whenever the current bank is full and the output slot
    // is empty or being emptied this cycle.
    assign rd_en      = full[rd_bank_reg] & (~out_valid_reg | out_ready);
    assign frame_read = rd_en & (&rd_cnt_reg);
    assign rd_addr    = K'(bit_reverse(BR_MAX_K'(rd_cnt_reg), K));
    assign rd_bank    = rd_bank_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = last_pend_reg;

    // Advance the read pointer on each read and load/hold/clear the output slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_cnt_reg    <= '0;
            rd_bank_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            last_pend_reg <= 1'b0;
        end else if (rd_en) begin
            rd_cnt_reg    <= rd_cnt_reg + K'(1);
            out_valid_reg <= 1'b1;
            last_pend_reg <= frame_read;
            if (frame_read) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            last_pend_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/bitrev_frame_ctrl.sv
// Frame sequencer and bank scheduler for a ping-pong bit-reversal buffer.
// Natural-order writes fill one bank while the other is read bit-reversed.
// Define BITREV_CTRL_STATS_EN to build the saturating producer stall counter.
module bitrev_frame_ctrl
    import bitrev_pkg::*;
#(
    parameter int K  = BR_K_DEF,
    parameter int FW = BR_FW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [FW-1:0] num_frames_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          buf_wr_en_o,
    output logic          buf_wr_bank_o,
    output logic [K-1:0]  buf_wr_addr_o,
    output logic          buf_rd_en_o,
    output logic          buf_rd_bank_o,
    output logic [K-1:0]  buf_rd_addr_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          out_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [FW-1:0] frames_out_o,
    output logic [31:0]   stall_cnt_o
);

    state_t        state_reg;
    logic [FW-1:0] target_reg;
    logic [FW-1:0] frames_in_reg;
    logic [FW-1:0] frames_out_reg;
    logic          done_reg;
    logic [K-1:0]  wr_cnt_reg;
    logic          wr_bank_reg;
    logic [1:0]    full_reg;
    logic [1:0]    full_next;

    logic          wr_fire;
    logic          wr_frame_end;
    logic          rd_en;
    logic          rd_bank;
    logic          frame_read;
    logic          out_valid;
    logic          out_last;
    logic          beat_last;

    assign in_ready_o   = (state_reg == RUN) & ~full_reg[wr_bank_reg];
    assign wr_fire      = in_valid_i & in_ready_o;
    assign wr_frame_end = wr_fire & (&wr_cnt_reg);
    assign beat_last    = out_valid & out_ready_i & out_last;

    assign buf_wr_en_o   = wr_fire;
    assign buf_wr_bank_o = wr_bank_reg;
    assign buf_wr_addr_o = wr_cnt_reg;
    assign buf_rd_en_o   = rd_en;
    assign buf_rd_bank_o = rd_bank;
    assign out_valid_o   = out_valid;
    assign out_last_o    = out_last;
    assign busy_o        = (state_reg != IDLE);
    assign done_o        = done_reg;
    assign frames_out_o  = frames_out_reg;

    bitrev_rd_seq #(
        .K(K)
    ) u_rd_seq (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (abort_i),
        .full       (full_reg),
        .out_ready  (out_ready_i),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (buf_rd_addr_o),
        .frame_read (frame_read),
        .out_valid  (out_valid),
        .out_last   (out_last)
    );

    // Full-flag update: a finishing read frees its bank first, then a
    // finishing write marks its bank, so a same-bank collision ends up full.
    always_comb begin
        full_next = full_reg;
        if (frame_read) begin
            full_next[rd_bank] = 1'b0;
        end
        if (wr_frame_end) begin
            full_next[wr_bank_reg] = 1'b1;
        end
    end

    // Write address counter, write bank pointer and bank occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            full_reg    <= 2'b00;
        end else begin
            full_reg <= full_next;
            if (wr_fire) begin
                wr_cnt_reg <= wr_cnt_reg + K'(1);
                if (&wr_cnt_reg) begin
                    wr_bank_reg <= ~wr_bank_reg;
                end
            end
        end
    end

    // Run control FSM with frame accounting and the registered done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            target_reg     <= '0;
            frames_in_reg  <= '0;
            frames_out_reg <= '0;
            done_reg       <= 1'b0;
        end else if (abort_i) begin
            state_reg      <= IDLE;
            frames_in_reg  <= '0;
            frames_out_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (wr_frame_end) begin
                frames_in_reg <= frames_in_reg + FW'(1);
            end
            if (beat_last) begin
                frames_out_reg <= frames_out_reg + FW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        target_reg     <= num_frames_i;
                        frames_in_reg  <= '0;
                        frames_out_reg <= '0;
                        state_reg      <= RUN;
                    end
                end
                RUN: begin
                    // Leave on the final write itself so no extra sample slips in.
                    if ((target_reg != '0) && wr_frame_end &&
                        (frames_in_reg + FW'(1) == target_reg)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat_last && (frames_out_reg + FW'(1) == target_reg)) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef BITREV_CTRL_STATS_EN
    logic [31:0] stall_cnt_reg;

    // Count producer stall cycles during a run; saturate, clear only on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (in_valid_i && !in_ready_o && busy_o && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bitrev_frame_ctrl.sv
// Scenario bench for bitrev_frame_ctrl with K=3: a bench-side buffer model
// stores written sample ids, expected bit-reversed output order is queued
// per completed input frame and compared against accepted output beats.
module tb_bitrev_frame_ctrl;

    localparam int K  = 3;
    localparam int FW = 16;
    localparam int N  = 1 << K;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [FW-1:0] num_frames;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [K-1:0]  wr_addr;
    logic          rd_en;
    logic          rd_bank;
    logic [K-1:0]  rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [FW-1:0] frames_out;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    bitrev_frame_ctrl #(.K(K), .FW(FW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .abort_i       (abort),
        .num_frames_i  (num_frames),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .buf_wr_en_o   (wr_en),
        .buf_wr_bank_o (wr_bank),
        .buf_wr_addr_o (wr_addr),
        .buf_rd_en_o   (rd_en),
        .buf_rd_bank_o (rd_bank),
        .buf_rd_addr_o (rd_addr),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_last_o    (out_last),
        .busy_o        (busy),
        .done_o        (done),
        .frames_out_o  (frames_out),
        .stall_cnt_o   (stall_cnt)
    );

    int   total = 0;
    int   bad   = 0;

    int   mem [2*N];
    int   in_data = 100;
    int   buf_data = 0;
    int   rd_pending = 0;
    logic rd_pending_vld = 1'b0;
    int   exp_data[$];
    logic exp_last[$];
    int   obs_data[$];
    logic obs_last[$];
    int   rd_addr_log[$];
    int   wr_seen, cyc, first_wr_cyc, first_vld_cyc, last_vld_cyc;
    int   done_cnt, hold_viol, first_wr_bank;
    logic prev_stuck, prev_last;

    function automatic int rev(input int j);
        int r;
        r = 0;
        for (int i = 0; i < K; i++) begin
            if ((j >> i) & 1) r = r | (1 << (K - 1 - i));
        end
        return r;
    endfunction

    task automatic model_clear();
        exp_data.delete(); exp_last.delete();
        obs_data.delete(); obs_last.delete();
        rd_addr_log.delete();
        wr_seen = 0; cyc = 0; first_wr_cyc = -1; first_vld_cyc = -1; last_vld_cyc = -1;
        done_cnt = 0; hold_viol = 0; first_wr_bank = -1;
        prev_stuck = 1'b0; prev_last = 1'b0;
    endtask

    // One clock cycle: observe handshakes at the falling edge, update the
    // buffer model, then return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (prev_stuck && (!out_valid || out_last !== prev_last)) hold_viol++;
        prev_stuck = out_valid && !out_ready && !abort && !rst;
        prev_last  = out_last;
        if (out_valid) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            last_vld_cyc = cyc;
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            obs_data.push_back(buf_data);
            obs_last.push_back(out_last);
        end
        rd_pending_vld = rd_en;
        if (rd_en) begin
            rd_pending = mem[int'(rd_bank) * N + int'(rd_addr)];
            rd_addr_log.push_back(int'(rd_addr));
        end
        if (wr_en) begin
            if (first_wr_cyc < 0) begin
                first_wr_cyc  = cyc;
                first_wr_bank = int'(wr_bank);
            end
            mem[int'(wr_bank) * N + int'(wr_addr)] = in_data;
            in_data++;
            wr_seen++;
            if (wr_seen % N == 0) begin
                for (int j = 0; j < N; j++) begin
                    exp_data.push_back(in_data - N + rev(j));
                    exp_last.push_back(j == N - 1);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rd_pending_vld) buf_data = rd_pending;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num_frames = '0;
        tick(); tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        num_frames = FW'(1);
        model_clear();
        tick(); tick();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (wr_en !== 1'b0)     begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        total++; if (rd_en !== 1'b0)     begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (frames_out !== '0)  begin bad++; $display("FAIL reset_frames_out got=%0d want=0", frames_out); end
        total++; if (stall_cnt !== '0)   begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        total++;
        if ({wr_bank, rd_bank, wr_addr, rd_addr} !== '0) begin
            bad++; $display("FAIL reset_pointers got=%b want=0", {wr_bank, rd_bank, wr_addr, rd_addr});
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        $display("test_reset checked");
    endtask

    task automatic test_two_frames();
        int lasts;
        do_reset();
        num_frames = FW'(2); start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; num_frames = FW'(5); in_valid = 1'b1;
        for (int c = 0; c < 100 && done_cnt == 0; c++) tick();
        in_valid = 1'b0;
        tick(); tick();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL two_done_pulses got=%0d want=1", done_cnt); end
        total++;
        if (first_vld_cyc - first_wr_cyc !== 9) begin
            bad++; $display("FAIL two_first_valid_latency got=%0d want=9", first_vld_cyc - first_wr_cyc);
        end
        total++;
        if (last_vld_cyc - first_vld_cyc !== 15) begin
            bad++; $display("FAIL two_valid_span got=%0d want=15", last_vld_cyc - first_vld_cyc);
        end
        total++; if (frames_out !== FW'(2)) begin bad++; $display("FAIL two_frames_out got=%0d want=2", frames_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL two_busy_after got=%b want=0", busy); end
        total++; if (wr_seen !== 16) begin bad++; $display("FAIL two_writes got=%0d want=16", wr_seen); end
        total++;
        if (rd_addr_log.size() !== 16) begin
            bad++; $display("FAIL two_read_count got=%0d want=16", rd_addr_log.size());
        end
        for (int i = 0; i < rd_addr_log.size(); i++) begin
            total++;
            if (rd_addr_log[i] !== rev(i % N)) begin
                bad++; $display("FAIL two_rd_addr[%0d] got=%0d want=%0d", i, rd_addr_log[i], rev(i % N));
            end
        end
        lasts = 0;
        while (obs_data.size() > 0) begin
            int od, ed; logic ol, el;
            od = obs_data.pop_front(); ol = obs_last.pop_front();
            total++;
            if (exp_data.size() == 0) begin
                bad++; $display("FAIL two_beat got data=%0d last=%0b want no beat", od, ol);
            end else begin
                ed = exp_data.pop_front(); el = exp_last.pop_front();
                if (el) lasts++;
                if (od !== ed || ol !== el) begin
                    bad++; $display("FAIL two_beat got data=%0d last=%0b want data=%0d last=%0b", od, ol, ed, el);
                end else $display("two_frames beat data=%0d last=%0b", od, ol);
            end
        end
        total++;
        if (exp_data.size() !== 0 || lasts !== 2) begin
            bad++; $display("FAIL two_beats_missing got left=%0d lasts=%0d want left=0 lasts=2", exp_data.size(), lasts);
        end
    endtask

    task automatic test_backpressure();
        int exp_stall, lasts;
`ifdef BITREV_CTRL_STATS_EN
        exp_stall = 4;
`else
        exp_stall = 0;
`endif
        do_reset();
        num_frames = '0; start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1;
        repeat (20) tick();
        total++; if (wr_seen !== 16) begin bad++; $display("FAIL bp_writes got=%0d want=16", wr_seen); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            bad++; $display("FAIL bp_out_hold got valid=%b last=%b want valid=1 last=0", out_valid, out_last);
        end
        total++; if (stall_cnt !== 32'(exp_stall)) begin
            bad++; $display("FAIL bp_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall);
        end
        out_ready = 1'b1;
        repeat (40) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_continuous_busy got=%b want=1", busy); end
        total++; if (hold_viol !== 0) begin bad++; $display("FAIL bp_hold_violations got=%0d want=0", hold_viol); end
        lasts = 0;
        while (obs_data.size() > 0) begin
            int od, ed; logic ol, el;
            od = obs_data.pop_front(); ol = obs_last.pop_front();
            total++;
            if (exp_data.size() == 0) begin
                bad++; $display("FAIL bp_beat got data=%0d last=%0b want no beat", od, ol);
            end else begin
                ed = exp_data.pop_front(); el = exp_last.pop_front();
                if (el) lasts++;
                if (od !== ed || ol !== el) begin
                    bad++; $display("FAIL bp_beat got data=%0d last=%0b want data=%0d last=%0b", od, ol, ed, el);
                end else $display("backpressure beat data=%0d last=%0b", od, ol);
            end
        end
        total++; if (frames_out !== FW'(lasts) || lasts < 3) begin
            bad++; $display("FAIL bp_frames_out got=%0d want=%0d (at least 3)", frames_out, lasts);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_abort_busy got=%b want=0", busy); end
    endtask

    task automatic test_toggle_ready();
        do_reset();
        num_frames = FW'(3); start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = (c % 2 == 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL tog_done_pulses got=%0d want=1", done_cnt); end
        total++; if (hold_viol !== 0) begin bad++; $display("FAIL tog_hold_violations got=%0d want=0", hold_viol); end
        total++; if (frames_out !== FW'(3)) begin bad++; $display("FAIL tog_frames_out got=%0d want=3", frames_out); end
        total++; if (obs_data.size() !== 24) begin bad++; $display("FAIL tog_beat_count got=%0d want=24", obs_data.size()); end
        total++; if (rd_addr_log.size() !== 24) begin bad++; $display("FAIL tog_read_count got=%0d want=24", rd_addr_log.size()); end
        while (obs_data.size() > 0) begin
            int od, ed; logic ol, el;
            od = obs_data.pop_front(); ol = obs_last.pop_front();
            total++;
            if (exp_data.size() == 0) begin
                bad++; $display("FAIL tog_beat got data=%0d last=%0b want no beat", od, ol);
            end else begin
                ed = exp_data.pop_front(); el = exp_last.pop_front();
                if (od !== ed || ol !== el) begin
                    bad++; $display("FAIL tog_beat got data=%0d last=%0b want data=%0d last=%0b", od, ol, ed, el);
                end else $display("toggle beat data=%0d last=%0b", od, ol);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        num_frames = FW'(2); start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        repeat (13) tick();
        total++; if (wr_addr !== K'(5) || wr_bank !== 1'b1) begin
            bad++; $display("FAIL abort_position got addr=%0d bank=%b want addr=5 bank=1", wr_addr, wr_bank);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL abort_full_flags rd_en got=%b want=0", rd_en); end
        total++; if ({wr_bank, rd_bank, wr_addr, rd_addr} !== '0) begin
            bad++; $display("FAIL abort_pointers got=%b want=0", {wr_bank, rd_bank, wr_addr, rd_addr});
        end
        while (obs_data.size() > 0) begin
            int od, ed; logic ol, el;
            od = obs_data.pop_front(); ol = obs_last.pop_front();
            total++;
            if (exp_data.size() == 0) begin
                bad++; $display("FAIL abort_pre_beat got data=%0d last=%0b want no beat", od, ol);
            end else begin
                ed = exp_data.pop_front(); el = exp_last.pop_front();
                if (od !== ed || ol !== el) begin
                    bad++; $display("FAIL abort_pre_beat got data=%0d last=%0b want data=%0d last=%0b", od, ol, ed, el);
                end else $display("abort pre beat data=%0d last=%0b", od, ol);
            end
        end
        model_clear();
        num_frames = FW'(1); start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 100 && done_cnt == 0; c++) tick();
        in_valid = 1'b0;
        tick();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_rerun_done got=%0d want=1", done_cnt); end
        total++; if (first_wr_bank !== 0) begin bad++; $display("FAIL abort_rerun_bank got=%0d want=0", first_wr_bank); end
        total++; if (frames_out !== FW'(1)) begin bad++; $display("FAIL abort_rerun_frames got=%0d want=1", frames_out); end
        total++; if (obs_data.size() !== N) begin bad++; $display("FAIL abort_rerun_beats got=%0d want=%0d", obs_data.size(), N); end
        while (obs_data.size() > 0) begin
            int od, ed; logic ol, el;
            od = obs_data.pop_front(); ol = obs_last.pop_front();
            total++;
            if (exp_data.size() == 0) begin
                bad++; $display("FAIL abort_rerun_beat got data=%0d last=%0b want no beat", od, ol);
            end else begin
                ed = exp_data.pop_front(); el = exp_last.pop_front();
                if (od !== ed || ol !== el) begin
                    bad++; $display("FAIL abort_rerun_beat got data=%0d last=%0b want data=%0d last=%0b", od, ol, ed, el);
                end else $display("abort rerun beat data=%0d last=%0b", od, ol);
            end
        end
    endtask

    task automatic test_rst_drain();
        do_reset();
        num_frames = FW'(1); start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1;
        repeat (N) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rst_pre_drain got busy=%b valid=%b want 1 1", busy, out_valid);
        end
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        tick();
        total++;
        if ({busy, in_ready, wr_en, rd_en, out_valid, out_last, done} !== '0 || frames_out !== '0 ||
            stall_cnt !== '0 || {wr_bank, rd_bank, wr_addr, rd_addr} !== '0) begin
            bad++; $display("FAIL rst_drain_outputs got ctl=%b frames=%0d stall=%0d ptr=%b want all 0",
                            {busy, in_ready, wr_en, rd_en, out_valid, out_last, done}, frames_out, stall_cnt,
                            {wr_bank, rd_bank, wr_addr, rd_addr});
        end
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_ignored busy got=%b want=0", busy); end
    endtask

    task automatic test_start_abort();
        do_reset();
        num_frames = FW'(1); start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_busy got=%b want=0", busy); end
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        total++; if (wr_seen !== 0) begin bad++; $display("FAIL start_abort_writes got=%0d want=0", wr_seen); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num_frames = '0;
        test_reset();
        test_two_frames();
        test_backpressure();
        test_toggle_ready();
        test_abort();
        test_rst_drain();
        test_start_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
